// File: rtl/rtc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// rtc_bus_arbiter
// Round-robin arbiter and bus sequencer for the shared RTC parallel port.
// Four requesters (seconds, minutes, hours, periodic read-back) compete for
// the bus. One requester is granted at a time. Each transaction runs an
// address phase, a data phase and a turnaround, so requesters never overlap.
//
// Ports:
//   clk           system clock, rising edge active
//   reset         asynchronous active-low reset
//   enable        1 allows new grants; an in-flight transaction always completes
//   req[3:0]      per-requester level request, held until its own done
//   wr[3:0]       per-requester direction (1 write, 0 read)
//   addr0..3      per-requester RTC register address
//   wdata0..3     per-requester write byte
//   bus_din       byte read back from the RTC bus
//   gnt[3:0]      one-hot grant, high during ADDR and DATA
//   done[3:0]     one-hot, single-cycle completion pulse (first TURN cycle)
//   rdata         captured read byte, held until the next read
//   bus_cs        chip select, high in ADDR and DATA
//   a_d           0 = address phase, 1 = data phase
//   w_r           1 during the DATA phase of a write
//   bus_oe        1 when this block drives bus_dout
//   bus_dout      address in ADDR, wdata in write DATA, 0x00 otherwise
// -----------------------------------------------------------------------------
module rtc_bus_arbiter #(
  parameter int ADDR_CYC = 4,
  parameter int DATA_CYC = 4,
  parameter int TURN_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] req,
  input  logic [3:0] wr,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] addr2,
  input  logic [7:0] addr3,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic [7:0] wdata2,
  input  logic [7:0] wdata3,
  input  logic [7:0] bus_din,
  output logic [3:0] gnt,
  output logic [3:0] done,
  output logic [7:0] rdata,
  output logic       bus_cs,
  output logic       a_d,
  output logic       w_r,
  output logic       bus_oe,
  output logic [7:0] bus_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    TURN = 2'd3
  } state_t;

  // Phase counters are loaded with (length - 1) and count down to zero.
  localparam logic [3:0] ADDR_LOAD = 4'(ADDR_CYC - 1);
  localparam logic [3:0] DATA_LOAD = 4'(DATA_CYC - 1);
  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC - 1);

  state_t     state_r, state_s;
  logic [3:0] cnt_r, cnt_s;
  logic [1:0] ptr_r, ptr_s;
  logic [1:0] idx_r, idx_s;
  logic       wr_lat_r, wr_lat_s;
  logic [7:0] addr_lat_r, addr_lat_s;
  logic [7:0] wdata_lat_r, wdata_lat_s;
  logic [1:0] sel_s;

  logic [3:0] gnt_s, done_s;
  logic [7:0] rdata_s, bus_dout_s;
  logic       bus_cs_s, a_d_s, w_r_s, bus_oe_s;

  function automatic logic [3:0] one_hot(input logic [1:0] idx);
    one_hot = 4'b0001 << idx;
  endfunction

  // First set request at or above ptr, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] ptr);
    logic       found;
    logic [1:0] cand;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req_v[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  function automatic logic [7:0] pick_byte(input logic [1:0] sel, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [7:0] b3);
    case (sel)
      2'd0:    pick_byte = b0;
      2'd1:    pick_byte = b1;
      2'd2:    pick_byte = b2;
      2'd3:    pick_byte = b3;
      default: pick_byte = 8'h00;
    endcase
  endfunction

  // Next-state, operand latch and next-output computation.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    ptr_s       = ptr_r;
    idx_s       = idx_r;
    wr_lat_s    = wr_lat_r;
    addr_lat_s  = addr_lat_r;
    wdata_lat_s = wdata_lat_r;
    rdata_s     = rdata;
    sel_s       = rr_pick(req, ptr_r);

    case (state_r)
      IDLE: begin
        if (enable && (req != 4'b0000)) begin
          state_s     = ADDR;
          cnt_s       = ADDR_LOAD;
          idx_s       = sel_s;
          ptr_s       = sel_s + 2'd1;
          wr_lat_s    = wr[sel_s];
          addr_lat_s  = pick_byte(sel_s, addr0, addr1, addr2, addr3);
          wdata_lat_s = pick_byte(sel_s, wdata0, wdata1, wdata2, wdata3);
        end else begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end
      end
      ADDR: begin
        if (cnt_r == 4'd0) begin
          state_s = DATA;
          cnt_s   = DATA_LOAD;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      DATA: begin
        if (cnt_r == 4'd0) begin
          state_s = TURN;
          cnt_s   = TURN_LOAD;
          // Read byte is taken on the last DATA cycle only.
          if (!wr_lat_r) begin
            rdata_s = bus_din;
          end else begin
            rdata_s = rdata;
          end
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      TURN: begin
        if (cnt_r == 4'd0) begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    gnt_s      = 4'b0000;
    done_s     = 4'b0000;
    bus_cs_s   = 1'b0;
    a_d_s      = 1'b0;
    w_r_s      = 1'b0;
    bus_oe_s   = 1'b0;
    bus_dout_s = 8'h00;
    case (state_s)
      ADDR: begin
        gnt_s      = one_hot(idx_s);
        bus_cs_s   = 1'b1;
        bus_oe_s   = 1'b1;
        bus_dout_s = addr_lat_s;
      end
      DATA: begin
        gnt_s    = one_hot(idx_s);
        bus_cs_s = 1'b1;
        a_d_s    = 1'b1;
        if (wr_lat_s) begin
          w_r_s      = 1'b1;
          bus_oe_s   = 1'b1;
          bus_dout_s = wdata_lat_s;
        end else begin
          w_r_s      = 1'b0;
          bus_oe_s   = 1'b0;
          bus_dout_s = 8'h00;
        end
      end
      TURN: begin
        // Pulse only on the DATA -> TURN transition.
        if (state_r == DATA) begin
          done_s = one_hot(idx_s);
        end else begin
          done_s = 4'b0000;
        end
      end
      IDLE: begin
        done_s = 4'b0000;
      end
      default: begin
        done_s = 4'b0000;
      end
    endcase
  end

  // State, operand latches and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      ptr_r       <= 2'd0;
      idx_r       <= 2'd0;
      wr_lat_r    <= 1'b0;
      addr_lat_r  <= 8'h00;
      wdata_lat_r <= 8'h00;
      gnt         <= 4'b0000;
      done        <= 4'b0000;
      rdata       <= 8'h00;
      bus_cs      <= 1'b0;
      a_d         <= 1'b0;
      w_r         <= 1'b0;
      bus_oe      <= 1'b0;
      bus_dout    <= 8'h00;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      ptr_r       <= ptr_s;
      idx_r       <= idx_s;
      wr_lat_r    <= wr_lat_s;
      addr_lat_r  <= addr_lat_s;
      wdata_lat_r <= wdata_lat_s;
      gnt         <= gnt_s;
      done        <= done_s;
      rdata       <= rdata_s;
      bus_cs      <= bus_cs_s;
      a_d         <= a_d_s;
      w_r         <= w_r_s;
      bus_oe      <= bus_oe_s;
      bus_dout    <= bus_dout_s;
    end
  end

endmodule

// File: doc/rtc_bus_arbiter.md
# rtc_bus_arbiter

Round-robin arbiter and bus sequencer for the shared RTC parallel port. Four field-adjust / refresh requesters (seconds, minutes, hours, periodic read-back) each present an address and data byte. The block grants one requester at a time and drives the multiplexed address/data bus through an address phase, a data phase and a turnaround. It sits between the per-field adjust FSMs and the RTC pin driver, so no two requesters ever overlap on the bus.

## Interface
Parameters:
- ADDR_CYC, 4, cycles in the address phase (1..15)
- DATA_CYC, 4, cycles in the data phase (1..15)
- TURN_CYC, 2, idle cycles after each transaction (2..15)

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
- enable  in  1  1 = new grants allowed; 0 = no new grant (in-flight transaction completes)
- req  in  4  per-requester request; level, held until own done
- wr  in  4  per-requester direction: 1 write, 0 read
- addr0..addr3  in  8 each  RTC register address per requester
- wdata0..wdata3  in  8 each  write byte per requester
- bus_din  in  8  byte read back from the RTC bus
- gnt  out  4  one-hot grant; high during ADDR and DATA only
- done  out  4  one-hot, one-cycle completion pulse to the granted requester
- rdata  out  8  captured read byte; valid while done is high and held until the next read
- bus_cs  out  1  chip select; high in ADDR and DATA
- a_d  out  1  0 = address phase, 1 = data phase
- w_r  out  1  1 during the DATA phase of a write; otherwise 0
- bus_oe  out  1  1 = block drives bus_dout (ADDR always; DATA only for write)
- bus_dout  out  8  address in ADDR, wdata in write DATA, 0x00 otherwise

## Operation
- All outputs are registered. Reset values: gnt=0, done=0, rdata=0x00, bus_cs=0, a_d=0, w_r=0, bus_oe=0, bus_dout=0x00, state=IDLE, rr pointer=0, phase counter=0.
- States: IDLE, ADDR, DATA, TURN.
- IDLE: if enable=1 and any req bit is set, select the first set bit searching from pointer upward, modulo 4.
  - Latch the selected index, its wr, addr and wdata.
  - Set pointer = index+1 mod 4.
  - Go to ADDR.
  - If enable=0 or req=0, stay in IDLE with all bus outputs at their reset values.
- ADDR: lasts ADDR_CYC cycles. Outputs: bus_cs=1, a_d=0, w_r=0, bus_oe=1, bus_dout=latched addr, gnt=one-hot(index).
- DATA: lasts DATA_CYC cycles. Outputs: bus_cs=1, a_d=1, gnt held.
  - Write: w_r=1, bus_oe=1, bus_dout=latched wdata.
  - Read: w_r=0, bus_oe=0, bus_dout=0x00. bus_din is sampled on the last DATA cycle into rdata.
- TURN: lasts TURN_CYC cycles. Outputs: bus_cs=0, a_d=0, w_r=0, bus_oe=0, gnt=0.
  - done=one-hot(index) in the first TURN cycle only.
  - Go to IDLE.
- Latched operands are captured once at grant. Requester input changes after grant do not affect the in-flight transaction.
- A req deasserted mid-transaction is ignored; the transaction completes and done still pulses.
- enable falling mid-transaction does not abort the transaction; it only blocks the next grant.
- A req still high when IDLE is re-entered is treated as a new request.
- Phase counter is 4-bit, loaded with (phase length − 1) on phase entry and decremented to 0.

## Timing
- req sampled high in IDLE at edge t: gnt and ADDR outputs valid from t+1.
- DATA runs from t+1+ADDR_CYC.
- done pulses at t+1+ADDR_CYC+DATA_CYC.
- IDLE is re-entered at t+1+ADDR_CYC+DATA_CYC+TURN_CYC. Earliest next grant is one cycle later.
- Defaults: 4 address + 4 data cycles, 11 cycles from grant to the next possible grant.
- Requester contract: drop req within TURN_CYC−1 cycles of seeing done.
- Simultaneous requests are resolved strictly by rotating pointer; no fixed priority and no starvation. With all four held, grant order is 0,1,2,3,0,…
- reset low at any cycle: outputs go to reset values immediately; no done for the aborted transaction; pointer returns to 0.

## Test plan
- Single write, requester 1 with addr=0x42, wdata=0x37 → 4 cycles bus_dout=0x42, a_d=0; then 4 cycles bus_dout=0x37, a_d=1, w_r=1; done=0010 at grant+8; gnt=0010 throughout ADDR/DATA.
- Read by requester 3, addr=0x21, bus_din=0x59 during DATA → bus_oe=0 and w_r=0 in DATA; rdata=0x59 when done=1000.
- req=1111 held continuously → grants 0001,0010,0100,1000,0001; 11-cycle spacing; never two gnt bits set.
- req[2] dropped and enable set to 0 in the middle of ADDR → transaction completes, done=0100 pulses, no further grant until enable=1.
- reset asserted during DATA of a write → all outputs 0 asynchronously, no done; after release, req=0011 grants requester 0 first (pointer reset).
- Operand change after grant (addr0 changed 0x42→0x43 during ADDR) → bus_dout stays 0x42.
